// File: rtl/bsg_arb_pkg.sv
// bsg_arb_pkg: search-direction constants and width helper shared by the arbiters
package bsg_arb_pkg;
  typedef enum logic {e_hi_to_lo = 1'b0, e_lo_to_hi = 1'b1} arb_dir_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bsg_arb_rr_pick.sv
// bsg_arb_rr_pick: rotate / fixed-priority / un-rotate picker starting one past ptr
module bsg_arb_rr_pick
  import bsg_arb_pkg::*;
#(
  parameter int inputs_p = 16,
  parameter int lo_to_hi_p = 0,
  localparam int tag_width_lp = clog2_min1(inputs_p)
) (
  input  logic [inputs_p-1:0]     reqs,
  input  logic [tag_width_lp-1:0] ptr,
  output logic [inputs_p-1:0]     one_hot,
  output logic [tag_width_lp-1:0] tag
);
  logic [tag_width_lp-1:0] idx;
  // walk from lowest to highest priority so the last hit is the winner
  always_comb begin
    one_hot = '0;
    tag = '0;
    idx = '0;
    for (int i = inputs_p; i >= 1; i--) begin
      idx = tag_width_lp'((lo_to_hi_p == int'(e_lo_to_hi)) ? (int'(ptr) + i) % inputs_p
                                                          : (int'(ptr) + inputs_p - i) % inputs_p);
      if (reqs[idx]) begin
        one_hot = '0;
        one_hot[idx] = 1'b1;
        tag = idx;
      end
    end
  end
endmodule

// File: rtl/bsg_arb_rr_lock.sv
// bsg_arb_rr_lock: round-robin arbiter that can hold a grant until a packet's last beat
module bsg_arb_rr_lock
  import bsg_arb_pkg::*;
#(
  parameter int inputs_p = 16,
  parameter int lo_to_hi_p = 0,
  parameter bit lock_en_p = 1'b1,
  localparam int tag_width_lp = clog2_min1(inputs_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    ready_i,
  input  logic [inputs_p-1:0]     reqs_i,
  input  logic [inputs_p-1:0]     last_i,
  output logic [inputs_p-1:0]     grants_o,
  output logic                    v_o,
  output logic [tag_width_lp-1:0] tag_o,
  output logic                    locked_o
);
  localparam logic [tag_width_lp-1:0] ptr_reset_lp =
    (lo_to_hi_p == int'(e_lo_to_hi)) ? tag_width_lp'(inputs_p - 1) : '0;
  logic [tag_width_lp-1:0] ptr_r, lock_idx_r, pick_tag;
  logic                    locked_r, hold;
  logic [inputs_p-1:0]     lock_mask, pick_reqs, pick_oh;
  always_comb begin
    lock_mask = '0;
    lock_mask[lock_idx_r] = 1'b1;
  end
  // while locked only the lock holder is visible, so the shared picker selects it or nothing
  assign pick_reqs = locked_r ? (reqs_i & lock_mask) : reqs_i;
  bsg_arb_rr_pick #(
    .inputs_p  (inputs_p),
    .lo_to_hi_p(lo_to_hi_p)
  ) pick (
    .reqs   (pick_reqs),
    .ptr    (ptr_r),
    .one_hot(pick_oh),
    .tag    (pick_tag)
  );
  assign grants_o = ready_i ? pick_oh : '0;
  assign v_o = |grants_o;
  assign tag_o = v_o ? pick_tag : '0;
  assign locked_o = locked_r;
  assign hold = lock_en_p && !last_i[tag_o];
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r <= ptr_reset_lp;
      locked_r <= 1'b0;
      lock_idx_r <= '0;
    end else if (v_o) begin
      ptr_r <= tag_o;
      locked_r <= hold;
      if (hold) lock_idx_r <= tag_o;
    end
  end
endmodule

// File: doc/bsg_arb_rr_lock.md
# bsg_arb_rr_lock

Parametrised round-robin arbiter with packet locking, the successor to the fixed-priority arbiter. Grants are one-hot and combinational, gated by `ready_i`. Unlike the fixed-priority arbiter, this block rotates priority after every accepted beat, so no requester starves. It can also hold a grant across a multi-beat packet until that requester's last beat. It sits in front of shared links and network-router output ports.

## Interface
- `inputs_p`, default 16: number of requesters; legal range 1..64.
- `lo_to_hi_p`, default 0: 0 = after reset, highest index has first priority and search runs downward; 1 = index 0 first, search runs upward.
- `lock_en_p`, default 1: 1 = grant held until a beat with `last_i` set transfers; 0 = every beat re-arbitrated.
- `tag_width_lp`, default max(1, clog2(`inputs_p`)): derived, not overridable.

Ports:
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  reset; asynchronous, active-low.
- `ready_i`  in  1  downstream accepts a beat this cycle.
- `reqs_i`  in  `inputs_p`  request per requester.
- `last_i`  in  `inputs_p`  final beat of packet, per requester; sampled only for the granted index.
- `grants_o`  out  `inputs_p`  one-hot grant; a transfer occurs when the bit is set.
- `v_o`  out  1  OR of `grants_o`.
- `tag_o`  out  `tag_width_lp`  encoded index of the granted requester; 0 when `v_o`=0.
- `locked_o`  out  1  lock currently held (registered state).

## Operation
- State:
  - `ptr_r`: index granted most recently.
  - `locked_r`: lock held flag.
  - `lock_idx_r`: index holding the lock.
- Reset values:
  - `ptr_r` = 0 if `lo_to_hi_p`=0, else `inputs_p`-1. The first search therefore starts at index `inputs_p`-1 or 0 respectively.
  - `locked_r` = 0 and `lock_idx_r` = 0.
  - Outputs are then `grants_o`=0, `v_o`=0, `tag_o`=0, `locked_o`=0, until requests arrive and `ready_i` is high.
- Unlocked pick:
  - Rotate `reqs_i` so the search starts one past `ptr_r` in the search direction, wrapping modulo `inputs_p`.
  - Fixed-priority pick, then un-rotate.
  - `grants_o` = pick AND `ready_i`.
- Locked:
  - `grants_o[lock_idx_r]` = `reqs_i[lock_idx_r]` AND `ready_i`; all other bits 0.
  - A locked requester that deasserts its request gets no grant, and the lock persists (a bubble). Other requesters stay blocked.
- Update on transfer (`v_o`=1):
  - `ptr_r` ← `tag_o`.
  - If `lock_en_p` and the granted requester's `last_i`=0: `locked_r` ← 1, `lock_idx_r` ← `tag_o`.
  - If `last_i`=1: `locked_r` ← 0.
- No transfer: all state holds.
- `ready_i`=0: no grants and no state change, regardless of requests.
- `lock_en_p`=0: `locked_r` is constant 0 and `last_i` is ignored.
- `inputs_p`=1: grant = `reqs_i[0]` & `ready_i`; `tag_o`=0.

## Timing
- Zero latency: `grants_o`, `v_o` and `tag_o` are combinational from `reqs_i`, `ready_i` and registered state. There is no path from `last_i` to `grants_o`.
- State updates at the rising `clk_i` edge of the transfer cycle. The next cycle's search starts one past the just-granted index.
- A single-beat packet (`last_i`=1 on its first beat) never sets the lock.
- Reset asserted mid-packet clears the lock immediately (asynchronously). After release, arbitration restarts from the reset pointer.
- Reset deassertion must be synchronised externally to `clk_i`.
- Simultaneous events: a new request arriving in the same cycle as another requester's `last_i` beat competes at the next edge only.

## Structure
- Package `bsg_arb_pkg` holds the direction constants (`e_hi_to_lo`, `e_lo_to_hi`) and a clog2-with-minimum-1 function. It is shared with the fixed arbiter.
- Sub-module `bsg_arb_rr_pick` is the combinational rotate / fixed-priority / un-rotate picker. Inputs: `reqs`, `ptr`; outputs: one-hot and tag. It is reused by the locked and unlocked paths, and by future weighted variants.
- Top level holds the three registers, lock muxing and `ready_i` gating. Target 150–250 lines total.

## Test plan
- Reset, `inputs_p`=4, `lo_to_hi_p`=0, `reqs_i`=4'b1111, `ready_i`=1, all `last_i`=1 → grant sequence 1000, 0100, 0010, 0001, 1000 on consecutive cycles; `tag_o` = 3, 2, 1, 0, 3.
- `ready_i`=0 for 3 cycles with `reqs_i`=4'b0101 → `grants_o`=0 and `v_o`=0 throughout. After `ready_i` rises, the grant goes to the index next in rotation from the pre-stall `ptr_r`.
- Lock: req2 issues a 3-beat packet (`last_i[2]` = 0, 0, 1) while req0 is continuously requesting → `grants_o`=0100 for 3 cycles, `locked_o`=1 on cycles 2–3, then 0001 on cycle 4.
- Bubble: req2 is locked and drops its request for 2 cycles while req1 requests → `grants_o`=0 for those cycles and `locked_o` stays 1. req2 resumes with `last_i`=1 → granted, lock cleared, req1 granted next.
- Reset pulse (`reset_n_i` low for 1 cycle) while locked on idx 3 → `locked_o`=0 asynchronously. After release with `reqs_i`=4'b1001, the grant goes to 1000.
- `lock_en_p`=0, `lo_to_hi_p`=1, `inputs_p`=5, all request with `last_i`=0 → grants rotate 0, 1, 2, 3, 4, 0 and `locked_o` is always 0.
